// File: rtl/vip_pkg.sv
// Shared constants for the VIP colour-space stages: fixed-point BT.601 full-range
// coefficients, offsets and datapath widths.
package vip_pkg;
   localparam int PIX_W      = 8;
   localparam int CHROMA_OFS = 128;
   localparam int RND        = 128;
   localparam int FRAC_BITS  = 8;

   localparam int COEF_RCR   = 359;
   localparam int COEF_GCB   = 88;
   localparam int COEF_GCR   = 183;
   localparam int COEF_BCB   = 454;

   localparam int PROD_W     = 18;
   localparam int SUM_W      = 20;
endpackage

// File: rtl/ycbcr444_rgb888_if.sv
// Video pixel bus: input YCbCr pixel with sync, output RGB pixel with delayed sync.
interface ycbcr444_rgb888_if;
   import vip_pkg::*;

   logic             per_frame_vsync;
   logic             per_frame_href;
   logic             per_frame_clken;
   logic [PIX_W-1:0] per_img_Y;
   logic [PIX_W-1:0] per_img_Cb;
   logic [PIX_W-1:0] per_img_Cr;

   logic             post_frame_vsync;
   logic             post_frame_href;
   logic             post_frame_clken;
   logic [PIX_W-1:0] post_img_red;
   logic [PIX_W-1:0] post_img_green;
   logic [PIX_W-1:0] post_img_blue;

   modport master (
      output per_frame_vsync, per_frame_href, per_frame_clken,
      output per_img_Y, per_img_Cb, per_img_Cr,
      input  post_frame_vsync, post_frame_href, post_frame_clken,
      input  post_img_red, post_img_green, post_img_blue
   );

   modport slave (
      input  per_frame_vsync, per_frame_href, per_frame_clken,
      input  per_img_Y, per_img_Cb, per_img_Cr,
      output post_frame_vsync, post_frame_href, post_frame_clken,
      output post_img_red, post_img_green, post_img_blue
   );
endinterface

// File: rtl/vip_sync_delay.sv
// Generic DEPTH-stage shift register for a bundle of sync bits; output lags input
// by DEPTH clocks, no back-pressure, cleared by synchronous reset.
module vip_sync_delay #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_dat,
   output logic [WIDTH-1:0] o_dat
);
   logic [WIDTH-1:0] r_sr [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else begin
         r_sr[0] <= i_dat;
         for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_dat = r_sr[DEPTH-1];
endmodule

// File: rtl/ycbcr444_rgb888.sv
// BT.601 full-range YCbCr444 -> RGB888, 3-stage free-running pipeline with matching
// sync delay; no back-pressure, RGB forced to black whenever delayed href is low.
module ycbcr444_rgb888
   import vip_pkg::*;
#(
   parameter int PIPE_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   ycbcr444_rgb888_if.slave  io_vid
);
   localparam logic signed [PROD_W-1:0] K_RCR = PROD_W'(COEF_RCR);
   localparam logic signed [PROD_W-1:0] K_GCB = PROD_W'(COEF_GCB);
   localparam logic signed [PROD_W-1:0] K_GCR = PROD_W'(COEF_GCR);
   localparam logic signed [PROD_W-1:0] K_BCB = PROD_W'(COEF_BCB);
   localparam logic signed [SUM_W-1:0]  K_RND = SUM_W'(RND);
   localparam logic signed [PIX_W:0]    K_OFS = (PIX_W+1)'(CHROMA_OFS);

   // Arithmetic shift right by FRAC_BITS, then saturate to the pixel range.
   function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [SUM_W-1:0] s);
      logic [SUM_W-FRAC_BITS-1:0] sh;
      sh = s[SUM_W-1:FRAC_BITS];
      if (sh[SUM_W-FRAC_BITS-1])           clamp_pix = '0;
      else if (|sh[SUM_W-FRAC_BITS-2:PIX_W]) clamp_pix = '1;
      else                                  clamp_pix = sh[PIX_W-1:0];
   endfunction

   logic signed [PIX_W:0]    w_cb;
   logic signed [PIX_W:0]    w_cr;
   logic signed [PROD_W-1:0] w_cb_x;
   logic signed [PROD_W-1:0] w_cr_x;
   logic signed [SUM_W-1:0]  w_y_x;
   logic [2:0]               w_sync;

   logic [2*PIX_W-1:0]       r_y256;
   logic signed [PROD_W-1:0] r_p_rcr;
   logic signed [PROD_W-1:0] r_p_gcb;
   logic signed [PROD_W-1:0] r_p_gcr;
   logic signed [PROD_W-1:0] r_p_bcb;
   logic signed [SUM_W-1:0]  r_sum_r;
   logic signed [SUM_W-1:0]  r_sum_g;
   logic signed [SUM_W-1:0]  r_sum_b;
   logic [PIX_W-1:0]         r_red;
   logic [PIX_W-1:0]         r_green;
   logic [PIX_W-1:0]         r_blue;

   assign w_cb   = $signed({1'b0, io_vid.per_img_Cb}) - K_OFS;
   assign w_cr   = $signed({1'b0, io_vid.per_img_Cr}) - K_OFS;
   assign w_cb_x = PROD_W'(w_cb);
   assign w_cr_x = PROD_W'(w_cr);
   assign w_y_x  = $signed({{(SUM_W-2*PIX_W){1'b0}}, r_y256});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_y256  <= '0;
         r_p_rcr <= '0;
         r_p_gcb <= '0;
         r_p_gcr <= '0;
         r_p_bcb <= '0;
         r_sum_r <= '0;
         r_sum_g <= '0;
         r_sum_b <= '0;
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
      end else begin
         r_y256  <= {io_vid.per_img_Y, {FRAC_BITS{1'b0}}};
         r_p_rcr <= w_cr_x * K_RCR;
         r_p_gcb <= w_cb_x * K_GCB;
         r_p_gcr <= w_cr_x * K_GCR;
         r_p_bcb <= w_cb_x * K_BCB;

         r_sum_r <= w_y_x + SUM_W'(r_p_rcr) + K_RND;
         r_sum_g <= w_y_x - SUM_W'(r_p_gcb) - SUM_W'(r_p_gcr) + K_RND;
         r_sum_b <= w_y_x + SUM_W'(r_p_bcb) + K_RND;

         r_red   <= clamp_pix(r_sum_r);
         r_green <= clamp_pix(r_sum_g);
         r_blue  <= clamp_pix(r_sum_b);
      end
   end

   vip_sync_delay #(
      .DEPTH (PIPE_LAT),
      .WIDTH (3)
   ) u_sync_delay (
      .clk   (clk),
      .rst   (rst),
      .i_dat ({io_vid.per_frame_vsync, io_vid.per_frame_href, io_vid.per_frame_clken}),
      .o_dat (w_sync)
   );

   assign io_vid.post_frame_vsync = w_sync[2];
   assign io_vid.post_frame_href  = w_sync[1];
   assign io_vid.post_frame_clken = w_sync[0];

   // Blanking outputs black so downstream DACs never see stale colour.
   assign io_vid.post_img_red     = w_sync[1] ? r_red   : '0;
   assign io_vid.post_img_green   = w_sync[1] ? r_green : '0;
   assign io_vid.post_img_blue    = w_sync[1] ? r_blue  : '0;
endmodule

// File: tb/tb_ycbcr444_rgb888.sv
// Bench for ycbcr444_rgb888: directed pixels, sync alignment, reset flush and
// an RGB -> YCbCr -> RGB round trip, checked through a 3-deep scoreboard.
module tb_ycbcr444_rgb888;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ycbcr444_rgb888_if vif ();

   ycbcr444_rgb888 #(.PIPE_LAT(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_vid (vif)
   );

   typedef struct {
      logic       vs;
      logic       hs;
      logic       ce;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      bit         tol;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc_n    = 0;

   function automatic exp_t zero_e();
      exp_t e;
      e.vs = 1'b0; e.hs = 1'b0; e.ce = 1'b0;
      e.r = 8'd0;  e.g = 8'd0;  e.b = 8'd0;
      e.tol = 1'b0;
      return e;
   endfunction

   function automatic logic [7:0] clamp8(input int v);
      if (v < 0)   return 8'd0;
      if (v > 255) return 8'd255;
      return v[7:0];
   endfunction

   // Reference conversion written from the fixed-point formulas.
   function automatic exp_t model(input logic vs, input logic hs, input logic ce,
                                  input int y, input int cb, input int cr);
      exp_t e;
      e.vs = vs; e.hs = hs; e.ce = ce; e.tol = 1'b0;
      e.r = hs ? clamp8((256*y + 359*(cr-128) + 128) >>> 8) : 8'd0;
      e.g = hs ? clamp8((256*y - 88*(cb-128) - 183*(cr-128) + 128) >>> 8) : 8'd0;
      e.b = hs ? clamp8((256*y + 454*(cb-128) + 128) >>> 8) : 8'd0;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, cyc_n, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      int d;
      d = int'(obs) - int'(exp);
      checks++;
      assert (!$isunknown(obs) && d <= 2 && d >= -2) else begin
         failures++;
         $error("FAIL %s cyc=%0d obs=%0d orig=%0d (tolerance 2)", tag, cyc_n, obs, exp);
      end
   endtask

   // One clock: drive at negedge, push expectation, compare the entry now due.
   task automatic cyc(input bit r, input exp_t e, input logic vs, input logic hs,
                      input logic ce, input logic [7:0] y, input logic [7:0] cb,
                      input logic [7:0] cr);
      exp_t o;
      rst                 = r;
      vif.per_frame_vsync = vs;
      vif.per_frame_href  = hs;
      vif.per_frame_clken = ce;
      vif.per_img_Y       = y;
      vif.per_img_Cb      = cb;
      vif.per_img_Cr      = cr;
      if (r) begin
         foreach (sb[i]) sb[i] = zero_e();
         sb.push_back(zero_e());
      end else begin
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      cyc_n++;
      o = sb.pop_front();
      chk("vsync", 8'(vif.post_frame_vsync), 8'(o.vs));
      chk("href",  8'(vif.post_frame_href),  8'(o.hs));
      chk("clken", 8'(vif.post_frame_clken), 8'(o.ce));
      if (o.tol) begin
         chk_tol("rt_red",   vif.post_img_red,   o.r);
         chk_tol("rt_green", vif.post_img_green, o.g);
         chk_tol("rt_blue",  vif.post_img_blue,  o.b);
      end else begin
         chk("red",   vif.post_img_red,   o.r);
         chk("green", vif.post_img_green, o.g);
         chk("blue",  vif.post_img_blue,  o.b);
      end
   endtask

   task automatic px(input bit r, input logic vs, input logic hs, input logic ce,
                     input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
      cyc(r, model(vs, hs, ce, int'(y), int'(cb), int'(cr)), vs, hs, ce, y, cb, cr);
   endtask

   // Active pixel with hand-computed expected colour.
   task automatic px_exp(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                         input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
      exp_t e;
      e = zero_e();
      e.hs = 1'b1; e.ce = 1'b1;
      e.r = er; e.g = eg; e.b = eb;
      cyc(1'b0, e, 1'b0, 1'b1, 1'b1, y, cb, cr);
   endtask

   // Front-end RGB -> YCbCr, then push the original RGB as a toleranced expectation.
   task automatic px_rt(input int r, input int g, input int b);
      exp_t e;
      logic [7:0] y, cb, cr;
      y  = clamp8((77*r + 150*g + 29*b + 128) >>> 8);
      cb = clamp8((-43*r - 85*g + 128*b + 32768 + 128) >>> 8);
      cr = clamp8((128*r - 107*g - 21*b + 32768 + 128) >>> 8);
      e = zero_e();
      e.hs = 1'b1; e.ce = 1'b1; e.tol = 1'b1;
      e.r = r[7:0]; e.g = g[7:0]; e.b = b[7:0];
      cyc(1'b0, e, 1'b0, 1'b1, 1'b1, y, cb, cr);
   endtask

   initial begin
      rst                 = 1'b1;
      vif.per_frame_vsync = 1'b0;
      vif.per_frame_href  = 1'b0;
      vif.per_frame_clken = 1'b0;
      vif.per_img_Y       = 8'd0;
      vif.per_img_Cb      = 8'd0;
      vif.per_img_Cr      = 8'd0;
      sb.push_back(zero_e());
      sb.push_back(zero_e());
      @(negedge clk);

      // Reset holds outputs at zero even with live inputs.
      px(1'b1, 1'b1, 1'b1, 1'b1, 8'd200, 8'd50, 8'd90);
      px(1'b1, 1'b1, 1'b1, 1'b1, 8'd200, 8'd50, 8'd90);
      px(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      repeat (3) px(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

      // Frame sync pulse during blanking with non-zero data.
      px(1'b0, 1'b1, 1'b0, 1'b0, 8'd77, 8'd99, 8'd11);
      px(1'b0, 1'b1, 1'b0, 1'b0, 8'd77, 8'd99, 8'd11);
      px(1'b0, 1'b0, 1'b0, 1'b0, 8'd77, 8'd99, 8'd11);

      px_exp(8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
      px_exp(8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255);
      px_exp(8'd0,   8'd255, 8'd255, 8'd178, 8'd0,   8'd225);
      px(1'b0, 1'b0, 1'b1, 1'b1, 8'd255, 8'd0, 8'd0);
      px(1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0, 8'd255);
      px(1'b0, 1'b0, 1'b0, 1'b0, 8'd60,  8'd70, 8'd80);
      px(1'b0, 1'b0, 1'b0, 1'b0, 8'd60,  8'd70, 8'd80);

      // 4-pixel line with a clken gap at the second pixel.
      px(1'b0, 1'b0, 1'b1, 1'b1, 8'd40,  8'd100, 8'd160);
      px(1'b0, 1'b0, 1'b1, 1'b0, 8'd90,  8'd140, 8'd120);
      px(1'b0, 1'b0, 1'b1, 1'b1, 8'd180, 8'd60,  8'd200);
      px(1'b0, 1'b0, 1'b1, 1'b1, 8'd220, 8'd30,  8'd10);
      repeat (3) px(1'b0, 1'b0, 1'b0, 1'b1, 8'd150, 8'd150, 8'd150);

      // Reset in the middle of an active line, inputs keep toggling afterwards.
      px(1'b0, 1'b0, 1'b1, 1'b1, 8'd100, 8'd200, 8'd30);
      px(1'b0, 1'b0, 1'b1, 1'b1, 8'd110, 8'd190, 8'd40);
      px(1'b1, 1'b0, 1'b1, 1'b1, 8'd120, 8'd180, 8'd50);
      px(1'b0, 1'b0, 1'b1, 1'b1, 8'd130, 8'd170, 8'd60);
      px(1'b0, 1'b0, 1'b1, 1'b0, 8'd140, 8'd160, 8'd70);
      px(1'b0, 1'b0, 1'b1, 1'b1, 8'd150, 8'd150, 8'd80);
      px(1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   8'd0,   8'd0);

      // Round trip: extremes first, then random colours.
      px_rt(0, 0, 0);
      px_rt(255, 255, 255);
      px_rt(255, 0, 0);
      px_rt(0, 255, 0);
      px_rt(0, 0, 255);
      px_rt(255, 255, 0);
      for (int i = 0; i < 10000; i++) begin
         px_rt(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)));
      end
      repeat (3) px(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
